// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake and payload bundle for pipe_stage_reg
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 72,
  parameter int DEPTH  = 1
);
  logic                       stall;
  logic                       flush;
  logic                       in_valid;
  logic [CTRL_W-1:0]          in_ctrl;
  logic [DATA_W-1:0]          in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [CTRL_W-1:0]          out_ctrl;
  logic [DATA_W-1:0]          out_data;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (
    output stall, flush, in_valid, in_ctrl, in_data,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
  modport slave (
    input  stall, flush, in_valid, in_ctrl, in_data,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-stage pipeline register with valid tracking, stall, flush and optional bubble collapsing
module pipe_stage_reg #(
  parameter int CTRL_W   = 4,
  parameter int DATA_W   = 72,
  parameter int DEPTH    = 1,
  parameter int COLLAPSE = 0
) (
  input logic            CLK,
  input logic            RESET,
  pipe_stage_reg_if.slave p
);
  localparam int OCC_W = $clog2(DEPTH+1);
  logic [DEPTH-1:0]  v, adv, sv, v_nxt;
  logic [CTRL_W-1:0] c  [DEPTH];
  logic [CTRL_W-1:0] sc [DEPTH];
  logic [DATA_W-1:0] d  [DEPTH];
  logic [DATA_W-1:0] sd [DEPTH];
  logic [OCC_W-1:0]  occ, cnt;
  always_comb begin
    adv = '0;
    sv = '0;
    v_nxt = '0;
    cnt = '0;
    adv[DEPTH-1] = (COLLAPSE != 0) ? (!p.stall || !v[DEPTH-1]) : !p.stall;
    for (int k = DEPTH-2; k >= 0; k--) adv[k] = (COLLAPSE != 0) ? (!v[k] || adv[k+1]) : !p.stall;
    sv[0] = p.in_valid;
    sc[0] = p.in_ctrl;
    sd[0] = p.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      sv[k] = v[k-1];
      sc[k] = c[k-1];
      sd[k] = d[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      v_nxt[k] = !p.flush && (adv[k] ? sv[k] : v[k]);
      cnt = cnt + OCC_W'(v_nxt[k]);
    end
  end
  // ctrl is masked by valid on every load so bubbles never carry live control bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        c[k] <= '0;
        d[k] <= '0;
      end
    end else begin
      v <= v_nxt;
      occ <= cnt;
      for (int k = 0; k < DEPTH; k++) begin
        if (p.flush) c[k] <= '0;
        else if (adv[k]) begin
          c[k] <= sc[k] & {CTRL_W{sv[k]}};
          d[k] <= sd[k];
        end
      end
    end
  end
  assign p.in_ready  = adv[0];
  assign p.out_valid = v[DEPTH-1];
  assign p.out_ctrl  = c[DEPTH-1];
  assign p.out_data  = d[DEPTH-1];
  assign p.occupancy = occ;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for three pipe_stage_reg configurations
module tb_pipe_stage_reg;
  logic CLK, RESET;
  int pass_cnt = 0;
  int total = 0;
  pipe_stage_reg_if #(.CTRL_W(4), .DATA_W(8), .DEPTH(3)) a ();
  pipe_stage_reg_if #(.CTRL_W(4), .DATA_W(8), .DEPTH(2)) b ();
  pipe_stage_reg_if #(.CTRL_W(4), .DATA_W(8), .DEPTH(3)) q ();
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .DEPTH(3), .COLLAPSE(0)) u_a (.CLK(CLK), .RESET(RESET), .p(a.slave));
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .DEPTH(2), .COLLAPSE(0)) u_b (.CLK(CLK), .RESET(RESET), .p(b.slave));
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .DEPTH(3), .COLLAPSE(1)) u_q (.CLK(CLK), .RESET(RESET), .p(q.slave));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  initial begin
    int occ_exp [7] = '{1, 2, 3, 3, 2, 1, 0};
    RESET = 1'b1;
    {a.stall, a.flush, b.stall, b.flush, q.stall, q.flush} = '0;
    a.in_valid = 1'b1; a.in_ctrl = 4'hF; a.in_data = 8'h11;
    b.in_valid = 1'b1; b.in_ctrl = 4'hF; b.in_data = 8'h22;
    q.in_valid = 1'b1; q.in_ctrl = 4'hF; q.in_data = 8'h33;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 32'(a.out_valid), 32'd0);
      chk("rst_ctrl", 32'(a.out_ctrl), 32'd0);
      chk("rst_data", 32'(a.out_data), 32'd0);
      chk("rst_occ", 32'(a.occupancy), 32'd0);
      chk("rst_occ_q", 32'(q.occupancy), 32'd0);
    end
    RESET = 1'b0;
    b.in_valid = 1'b0;
    q.in_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      a.in_valid = (i <= 4);
      a.in_ctrl = (i <= 4) ? 4'h3 : 4'hF;
      a.in_data = (i <= 4) ? 8'(i) : 8'(8'h50 + i);
      tick();
      chk("stream_occ", 32'(a.occupancy), 32'(occ_exp[i-1]));
      if (i >= 3 && i <= 6) begin
        chk("stream_data", 32'(a.out_data), 32'(i - 2));
        chk("stream_valid", 32'(a.out_valid), 32'd1);
        chk("stream_ctrl", 32'(a.out_ctrl), 32'h3);
      end
    end
    chk("inv_valid", 32'(a.out_valid), 32'd0);
    chk("inv_ctrl", 32'(a.out_ctrl), 32'd0);
    chk("inv_data", 32'(a.out_data), 32'h55);
    b.in_valid = 1'b1; b.in_ctrl = 4'h1; b.in_data = 8'd5;
    tick();
    b.in_data = 8'd6;
    tick();
    chk("stall_pre", 32'(b.out_data), 32'd5);
    b.in_data = 8'd7;
    b.stall = 1'b1;
    #1;
    chk("stall_ready", 32'(b.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", 32'(b.out_data), 32'd5);
      chk("stall_ready", 32'(b.in_ready), 32'd0);
      chk("stall_occ", 32'(b.occupancy), 32'd2);
    end
    b.stall = 1'b0;
    b.in_valid = 1'b0;
    #1;
    chk("release_ready", 32'(b.in_ready), 32'd1);
    tick();
    chk("release_data", 32'(b.out_data), 32'd6);
    q.in_valid = 1'b1; q.in_ctrl = 4'h2; q.in_data = 8'hA;
    tick();
    q.in_valid = 1'b0;
    tick();
    tick();
    chk("col_out", 32'(q.out_data), 32'hA);
    chk("col_occ1", 32'(q.occupancy), 32'd1);
    q.stall = 1'b1;
    q.in_valid = 1'b1; q.in_data = 8'hB;
    #1;
    chk("col_ready_b", 32'(q.in_ready), 32'd1);
    tick();
    q.in_data = 8'hC;
    #1;
    chk("col_ready_c", 32'(q.in_ready), 32'd1);
    tick();
    q.in_data = 8'hD;
    #1;
    chk("col_occ3", 32'(q.occupancy), 32'd3);
    chk("col_ready_full", 32'(q.in_ready), 32'd0);
    chk("col_hold", 32'(q.out_data), 32'hA);
    chk("col_ctrl", 32'(q.out_ctrl), 32'h2);
    q.stall = 1'b0;
    q.in_valid = 1'b0;
    tick();
    chk("col_next", 32'(q.out_data), 32'hB);
    a.in_valid = 1'b1; a.in_ctrl = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      a.in_data = 8'(8'h21 + i);
      tick();
    end
    chk("full_ctrl", 32'(a.out_ctrl), 32'hB);
    chk("full_occ", 32'(a.occupancy), 32'd3);
    a.flush = 1'b1;
    a.stall = 1'b1;
    tick();
    a.flush = 1'b0;
    a.stall = 1'b0;
    a.in_valid = 1'b0;
    chk("flush_valid", 32'(a.out_valid), 32'd0);
    chk("flush_ctrl", 32'(a.out_ctrl), 32'd0);
    chk("flush_occ", 32'(a.occupancy), 32'd0);
    chk("flush_data", 32'(a.out_data), 32'h21);
    b.in_valid = 1'b1; b.in_data = 8'h77;
    tick();
    tick();
    b.stall = 1'b1;
    b.flush = 1'b1;
    RESET = 1'b1;
    tick();
    chk("rst_stall_data", 32'(b.out_data), 32'd0);
    chk("rst_stall_valid", 32'(b.out_valid), 32'd0);
    chk("rst_stall_occ", 32'(b.occupancy), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
